udp_rx: RTL and testbench
=========================

Name: udp_rx

Overview:
GMII-side UDP/IPv4 receiver. It is the receive counterpart of the board's UDP transmit path and sits between the PHY GMII RX interface and the host-command/loopback logic. It strips the preamble/SFD and the Ethernet, IPv4 and UDP headers, and filters on board MAC, IP and port. Accepted payload is packed MSB-first into OUT_BYTES-wide words. FCS is not checked; trailing pad and FCS bytes are discarded.

Parameters:
OUT_BYTES, 4, payload bytes per output word (1..16); rec_data width = OUT_BYTES*8
MIN_IHL, 5, minimum legal IPv4 IHL in 32-bit words

Ports:
clk  in  1  GMII RX clock (125 MHz); single clock domain
rst  in  1  synchronous, active-high reset
BOARD_MAC  in  48  local MAC; quasi-static
BOARD_IP  in  32  local IPv4 address; quasi-static
BOARD_PORT  in  16  local UDP port; quasi-static
gmii_rx_dv  in  1  GMII receive data valid
gmii_rxd  in  8  GMII receive byte
rec_en  out  1  one-cycle strobe; rec_data valid
rec_data  out  OUT_BYTES*8  payload word, first byte in MSBs
rec_pkt_done  out  1  one-cycle strobe; last payload word delivered
rec_byte_num  out  16  UDP payload byte count (UDP length - 8); valid from end of UDP header until next frame
rec_err  out  1  one-cycle strobe; accepted frame truncated (dv low before payload complete)
src_ip  out  32  sender IP of last accepted frame
src_port  out  16  sender UDP port of last accepted frame

Behaviour:
- Reset (rst=1 at a clk edge): every output is 0 and the FSM is in IDLE. Reset mid-frame aborts the frame; no done or err strobes are produced.
- All outputs are registered. A strobe is high in the cycle after the edge that samples the byte causing it.
- Byte counter cnt is 16 bits and clears on every state transition.
- FSM states: IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END.
- At any state other than IDLE/RX_END, dv=0 returns the FSM to IDLE. If the state was RX_DATA, rec_err pulses once.
- IDLE: dv=1 and rxd=0x55 -> PREAMBLE (cnt=1).
- PREAMBLE: cnt 1..6 require 0x55; cnt 7 requires 0xD5 -> ETH_HEAD. Any other byte -> RX_END.
- ETH_HEAD: 14 bytes, cnt 0..13.
  - Bytes 0-5 (dest MAC) must equal BOARD_MAC or FF:FF:FF:FF:FF:FF.
  - Bytes 12-13 must equal 0x0800.
  - Pass/fail is decided at byte 13: pass -> IP_HEAD, fail -> RX_END.
- IP_HEAD: hdr_len = IHL*4.
  - Byte 0 upper nibble must be 4; IHL is taken from the lower nibble.
  - IHL < MIN_IHL -> RX_END immediately.
  - Byte 9 must be 17 (UDP).
  - Bytes 12-15 are latched as a candidate src_ip.
  - Bytes 16-19 must equal BOARD_IP.
  - Option bytes 20..hdr_len-1 are skipped.
  - At byte hdr_len-1: pass -> UDP_HEAD, fail -> RX_END.
  - IP checksum and total length are not checked.
- UDP_HEAD: 8 bytes.
  - Bytes 0-1 are latched as candidate src_port.
  - Bytes 2-3 must equal BOARD_PORT.
  - Bytes 4-5 give udp_len; bytes 6-7 (checksum) are ignored.
  - At byte 7, filter pass and udp_len >= 8 -> rec_byte_num = udp_len-8, src_ip/src_port committed.
  - If rec_byte_num = 0: rec_pkt_done pulses with no rec_en, -> RX_END. Otherwise -> RX_DATA.
  - Fail -> RX_END; rec_byte_num, src_ip and src_port are unchanged.
- RX_DATA: bytes are shifted into a packing register, first byte in bits [OUT_BYTES*8-1 -: 8].
  - rec_en pulses each time OUT_BYTES bytes have been collected.
  - On the final payload byte (cnt = rec_byte_num-1), the partial word is emitted left-aligned with unused low bytes zero.
  - rec_pkt_done pulses in the same cycle as that final rec_en. -> RX_END.
- RX_END: discards all bytes (pad, FCS, rejected frame) until dv=0 -> IDLE. A new frame needs at least one dv=0 cycle.
- Packing register clears at the start of every frame.
- rec_en, rec_pkt_done and rec_err are never high in the same cycle as a reset.

Test Plan:
- Frame: dest MAC 00:11:22:33:44:55 = BOARD_MAC, dest IP C0A8010A = BOARD_IP, dest port 1234 = BOARD_PORT, src 192.168.1.102:5000, payload 01..08, OUT_BYTES=4 -> rec_en x2 with 0x01020304 then 0x05060708; rec_pkt_done with the second; rec_byte_num=8; src_ip=C0A80166; src_port=5000.
- Same frame with 6-byte payload + 12 pad bytes + FCS -> rec_data 0x01020304 then 0x05060000; one rec_pkt_done; pad and FCS produce no strobes.
- Dest port 1235, or ethertype 0x0806, or IP protocol 6 -> no rec_en/done/err; src_ip and rec_byte_num keep the previous values; the following valid frame is accepted.
- Broadcast dest MAC with correct IP/port -> accepted. IHL=6 with 4 option bytes -> payload correctly aligned. IHL=4 -> rejected.
- dv dropped after 5 of 8 payload bytes -> one rec_en (0x01020304), one rec_err, no rec_pkt_done; the next frame is accepted normally.
- rst held one cycle during IP header -> all outputs 0 next cycle, no strobes. Back-to-back frames with a 1-cycle dv gap -> both accepted.

Source files
------------

// File: rtl/udp_rx.sv
// udp_rx: GMII-side UDP/IPv4 receiver.
// Strips the preamble/SFD and the Ethernet, IPv4 and UDP headers, filters on
// the board MAC (or broadcast), IPv4 address and UDP port, and packs accepted
// payload MSB-first into OUT_BYTES-wide words. FCS is not checked; pad and FCS
// bytes after the payload are discarded.
//
// Ports:
//   clk, rst              GMII RX clock, synchronous active-high reset
//   BOARD_MAC/IP/PORT     local addresses (quasi-static)
//   gmii_rx_dv, gmii_rxd  GMII receive data valid / byte
//   rec_en                one-cycle strobe, rec_data holds a payload word
//   rec_data              payload word, first byte in the MSBs
//   rec_pkt_done          one-cycle strobe with the last payload word
//   rec_byte_num          UDP payload byte count of the last accepted frame
//   rec_err               one-cycle strobe, accepted frame cut short by dv=0
//   src_ip, src_port      sender of the last accepted frame
//   dbg_state             current FSM state (state_t encoding)
//
// There is no flow control: every output is a registered strobe or a held
// value, and a strobe rises in the cycle after the clock edge that sampled the
// byte causing it.
module udp_rx #(
  parameter int OUT_BYTES = 4,
  parameter int MIN_IHL   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [47:0]            BOARD_MAC,
  input  logic [31:0]            BOARD_IP,
  input  logic [15:0]            BOARD_PORT,
  input  logic                   gmii_rx_dv,
  input  logic [7:0]             gmii_rxd,
  output logic                   rec_en,
  output logic [OUT_BYTES*8-1:0] rec_data,
  output logic                   rec_pkt_done,
  output logic [15:0]            rec_byte_num,
  output logic                   rec_err,
  output logic [31:0]            src_ip,
  output logic [15:0]            src_port,
  output logic [2:0]             dbg_state
);
  localparam int W = OUT_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HEAD, IP_HEAD, UDP_HEAD, RX_DATA, RX_END
  } state_t;

  state_t       state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  // Per-header filter flags: uc = unicast MAC match, bc = broadcast MAC,
  // ok = every other check of the current header so far.
  logic         uc_q, uc_d, bc_q, bc_d, ok_q, ok_d;
  logic [3:0]   ihl_q, ihl_d;
  logic [31:0]  ip_cand_q, ip_cand_d;
  logic [15:0]  port_cand_q, port_cand_d;
  logic [15:0]  udp_len_q, udp_len_d;
  logic [W-1:0] pack_q, pack_d;
  logic [4:0]   bidx_q, bidx_d;
  logic         rec_en_q, rec_en_d, done_q, done_d, err_q, err_d;
  logic [W-1:0] rec_data_q, rec_data_d;
  logic [15:0]  byte_num_q, byte_num_d;
  logic [31:0]  src_ip_q, src_ip_d;
  logic [15:0]  src_port_q, src_port_d;

  logic [15:0]  hdr_last;   // index of the last IPv4 header byte
  logic [W-1:0] word;       // packing register with the current byte placed

  assign hdr_last = {10'd0, ihl_q, 2'b00} - 16'd1;

  // Bytes are written at their final position, so a partial word is already
  // left-aligned with zero low bytes.
  always_comb begin
    word = pack_q;
    for (int i = 0; i < OUT_BYTES; i++) begin
      if (bidx_q == 5'(i)) word[W-1-8*i -: 8] = gmii_rxd;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    uc_d        = uc_q;
    bc_d        = bc_q;
    ok_d        = ok_q;
    ihl_d       = ihl_q;
    ip_cand_d   = ip_cand_q;
    port_cand_d = port_cand_q;
    udp_len_d   = udp_len_q;
    pack_d      = pack_q;
    bidx_d      = bidx_q;
    rec_en_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rec_data_d  = rec_data_q;
    byte_num_d  = byte_num_q;
    src_ip_d    = src_ip_q;
    src_port_d  = src_port_q;

    if (state_q != IDLE && state_q != RX_END && !gmii_rx_dv) begin
      state_d = IDLE;
      err_d   = (state_q == RX_DATA);
    end else begin
      case (state_q)
        IDLE: begin
          if (gmii_rx_dv && gmii_rxd == 8'h55) begin
            state_d = PREAMBLE;
            pack_d  = '0;
            bidx_d  = '0;
          end
        end
        PREAMBLE: begin
          if (cnt_q == 16'd7) state_d = (gmii_rxd == 8'hD5) ? ETH_HEAD : RX_END;
          else if (gmii_rxd != 8'h55) state_d = RX_END;
        end
        ETH_HEAD: begin
          for (int i = 0; i < 6; i++) begin
            if (cnt_q == 16'(i)) begin
              if (gmii_rxd != BOARD_MAC[47-8*i -: 8]) uc_d = 1'b0;
              if (gmii_rxd != 8'hFF) bc_d = 1'b0;
            end
          end
          if (cnt_q == 16'd12 && gmii_rxd != 8'h08) ok_d = 1'b0;
          if (cnt_q == 16'd13 && gmii_rxd != 8'h00) ok_d = 1'b0;
          if (cnt_q == 16'd13) state_d = ((uc_d || bc_d) && ok_d) ? IP_HEAD : RX_END;
        end
        IP_HEAD: begin
          if (cnt_q == 16'd0) begin
            ihl_d = gmii_rxd[3:0];
            if (gmii_rxd[7:4] != 4'd4) ok_d = 1'b0;
            if (gmii_rxd[3:0] < 4'(MIN_IHL)) state_d = RX_END;
          end else begin
            if (cnt_q == 16'd9 && gmii_rxd != 8'd17) ok_d = 1'b0;
            if (cnt_q >= 16'd12 && cnt_q <= 16'd15) ip_cand_d = {ip_cand_q[23:0], gmii_rxd};
            for (int i = 0; i < 4; i++) begin
              if (cnt_q == 16'(16 + i) && gmii_rxd != BOARD_IP[31-8*i -: 8]) ok_d = 1'b0;
            end
            // ihl_q was latched at byte 0, so the header end is known here.
            if (cnt_q == hdr_last) state_d = ok_d ? UDP_HEAD : RX_END;
          end
        end
        UDP_HEAD: begin
          if (cnt_q <= 16'd1) port_cand_d = {port_cand_q[7:0], gmii_rxd};
          if (cnt_q == 16'd2 && gmii_rxd != BOARD_PORT[15:8]) ok_d = 1'b0;
          if (cnt_q == 16'd3 && gmii_rxd != BOARD_PORT[7:0]) ok_d = 1'b0;
          if (cnt_q == 16'd4 || cnt_q == 16'd5) udp_len_d = {udp_len_q[7:0], gmii_rxd};
          if (cnt_q == 16'd7) begin
            if (ok_d && udp_len_q >= 16'd8) begin
              byte_num_d = udp_len_q - 16'd8;
              src_ip_d   = ip_cand_q;
              src_port_d = port_cand_q;
              if (udp_len_q == 16'd8) begin
                done_d  = 1'b1;
                state_d = RX_END;
              end else begin
                state_d = RX_DATA;
              end
            end else begin
              state_d = RX_END;
            end
          end
        end
        RX_DATA: begin
          if (bidx_q == 5'(OUT_BYTES - 1) || cnt_q == byte_num_q - 16'd1) begin
            rec_en_d   = 1'b1;
            rec_data_d = word;
            pack_d     = '0;
            bidx_d     = '0;
            if (cnt_q == byte_num_q - 16'd1) begin
              done_d  = 1'b1;
              state_d = RX_END;
            end
          end else begin
            pack_d = word;
            bidx_d = bidx_q + 5'd1;
          end
        end
        RX_END: begin
          if (!gmii_rx_dv) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    // Every state change restarts the byte count and the header checks.
    if (state_d != state_q) begin
      cnt_d = (state_d == PREAMBLE) ? 16'd1 : 16'd0;
      uc_d  = 1'b1;
      bc_d  = 1'b1;
      ok_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      uc_q        <= 1'b0;
      bc_q        <= 1'b0;
      ok_q        <= 1'b0;
      ihl_q       <= '0;
      ip_cand_q   <= '0;
      port_cand_q <= '0;
      udp_len_q   <= '0;
      pack_q      <= '0;
      bidx_q      <= '0;
      rec_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rec_data_q  <= '0;
      byte_num_q  <= '0;
      src_ip_q    <= '0;
      src_port_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      uc_q        <= uc_d;
      bc_q        <= bc_d;
      ok_q        <= ok_d;
      ihl_q       <= ihl_d;
      ip_cand_q   <= ip_cand_d;
      port_cand_q <= port_cand_d;
      udp_len_q   <= udp_len_d;
      pack_q      <= pack_d;
      bidx_q      <= bidx_d;
      rec_en_q    <= rec_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rec_data_q  <= rec_data_d;
      byte_num_q  <= byte_num_d;
      src_ip_q    <= src_ip_d;
      src_port_q  <= src_port_d;
    end
  end

  assign rec_en       = rec_en_q;
  assign rec_data     = rec_data_q;
  assign rec_pkt_done = done_q;
  assign rec_byte_num = byte_num_q;
  assign rec_err      = err_q;
  assign src_ip       = src_ip_q;
  assign src_port     = src_port_q;
  assign dbg_state    = state_q;
endmodule

// File: tb/tb_udp_rx.sv
// tb_udp_rx: self-checking bench for udp_rx. Frames are assembled from field
// values; a field-level model decides acceptance and the expected word stream.
module tb_udp_rx;
  localparam int OB = 4;
  localparam int W  = OB * 8;
  localparam int MIN_IHL = 5;
  localparam logic [47:0] MAC  = 48'h0011_2233_4455;
  localparam logic [31:0] IP   = 32'hC0A8_010A;
  localparam logic [15:0] PORT = 16'd1234;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         dv;
  logic [7:0]   rxd;
  logic         rec_en, rec_pkt_done, rec_err;
  logic [W-1:0] rec_data;
  logic [15:0]  rec_byte_num, src_port;
  logic [31:0]  src_ip;
  logic [2:0]   dbg_state;

  always #4 clk = ~clk;

  udp_rx #(.OUT_BYTES(OB), .MIN_IHL(MIN_IHL)) dut (
    .clk(clk), .rst(rst),
    .BOARD_MAC(MAC), .BOARD_IP(IP), .BOARD_PORT(PORT),
    .gmii_rx_dv(dv), .gmii_rxd(rxd),
    .rec_en(rec_en), .rec_data(rec_data), .rec_pkt_done(rec_pkt_done),
    .rec_byte_num(rec_byte_num), .rec_err(rec_err),
    .src_ip(src_ip), .src_port(src_port), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [W:0] exp_q[$];   // {done, word}
  logic [W:0] got_q[$];
  int exp_done_only = 0, got_done_only = 0;
  int exp_err = 0, got_err = 0;
  logic [31:0] m_src_ip = '0;
  logic [15:0] m_src_port = '0, m_byte_num = '0;

  // ---------------- frame fields ----------------
  logic [47:0] f_mac;
  logic [15:0] f_type, f_sport, f_dport, f_ulen;
  logic [3:0]  f_ver, f_ihl;
  logic [7:0]  f_proto;
  logic [31:0] f_sip, f_dip;
  logic [7:0]  pay[$];
  int          f_pad;
  logic [7:0]  frm[$];
  int          pay_start;

  always @(negedge clk) begin
    if (rec_en) got_q.push_back({rec_pkt_done, rec_data});
    else if (rec_pkt_done) got_done_only++;
    if (rec_err) got_err++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_be(input logic [47:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) frm.push_back(v[8*i +: 8]);
  endtask

  task automatic set_good(input int n);
    f_mac = MAC; f_type = 16'h0800; f_ver = 4'd4; f_ihl = 4'd5; f_proto = 8'd17;
    f_sip = {24'hC0A801, 8'($urandom_range(1, 254))}; f_dip = IP;
    f_sport = 16'($urandom_range(1024, 65535)); f_dport = PORT;
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    f_ulen = 16'(n + 8); f_pad = 4;
  endtask

  task automatic set_seq(input int n);   // payload 01, 02, ... n
    set_good(n);
    f_sip = 32'hC0A8_0166; f_sport = 16'd5000;
    pay.delete();
    for (int i = 1; i <= n; i++) pay.push_back(8'(i));
  endtask

  task automatic build();
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    push_be(f_mac, 6);
    push_be(48'h0200_DEAD_BEEF, 6);
    push_be(48'(f_type), 2);
    frm.push_back({f_ver, f_ihl});
    frm.push_back(8'h00);
    push_be(48'(16'(20 + 8 + pay.size())), 2);
    push_be(48'h0, 4);
    frm.push_back(8'd64);
    frm.push_back(f_proto);
    push_be(48'h0, 2);
    push_be(48'(f_sip), 4);
    push_be(48'(f_dip), 4);
    for (int i = 0; i < (int'(f_ihl) - 5) * 4; i++) frm.push_back(8'($urandom_range(0, 255)));
    push_be(48'(f_sport), 2);
    push_be(48'(f_dport), 2);
    push_be(48'(f_ulen), 2);
    push_be(48'h0, 2);
    pay_start = frm.size();
    foreach (pay[i]) frm.push_back(pay[i]);
    for (int i = 0; i < f_pad; i++) frm.push_back(8'($urandom_range(0, 255)));
  endtask

  // keep < 0: whole frame delivered; otherwise dv drops after keep payload bytes.
  task automatic model(input int keep);
    bit acc;
    int n, lim;
    logic [W-1:0] w;
    acc = (f_mac == MAC || f_mac == 48'hFFFF_FFFF_FFFF) && f_type == 16'h0800 &&
          f_ver == 4'd4 && int'(f_ihl) >= MIN_IHL && f_proto == 8'd17 &&
          f_dip == IP && f_dport == PORT && f_ulen >= 16'd8;
    if (!acc) return;
    n = int'(f_ulen) - 8;
    m_src_ip = f_sip; m_src_port = f_sport; m_byte_num = 16'(n);
    if (n == 0) begin
      exp_done_only++;
      return;
    end
    lim = (keep < 0 || keep >= n) ? n : keep;
    for (int i = 0; i < n; i += OB) begin
      if (lim < n && i + OB > lim) break;
      w = '0;
      for (int j = 0; j < OB; j++) w = (w << 8) | W'((i + j < n) ? pay[i + j] : 8'h00);
      exp_q.push_back({(i + OB >= n) && lim == n, w});
    end
    if (lim < n) exp_err++;
  endtask

  task automatic send(input int keep, input int gap);
    int last;
    last = (keep < 0) ? frm.size() : pay_start + keep;
    for (int i = 0; i < last; i++) begin
      @(negedge clk); dv = 1'b1; rxd = frm[i];
    end
    repeat (gap) begin
      @(negedge clk); dv = 1'b0; rxd = 8'h00;
    end
  endtask

  task automatic check(input string tag);
    repeat (3) @(negedge clk);
    chk({tag, "_nwords"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_done_only"}, 64'(got_done_only), 64'(exp_done_only));
    chk({tag, "_err"}, 64'(got_err), 64'(exp_err));
    chk({tag, "_src_ip"}, 64'(src_ip), 64'(m_src_ip));
    chk({tag, "_src_port"}, 64'(src_port), 64'(m_src_port));
    chk({tag, "_byte_num"}, 64'(rec_byte_num), 64'(m_byte_num));
    got_q.delete(); exp_q.delete();
    got_done_only = 0; exp_done_only = 0; got_err = 0; exp_err = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_en"}, 64'(rec_en), 64'd0);
    chk({tag, "_data"}, 64'(rec_data), 64'd0);
    chk({tag, "_done"}, 64'(rec_pkt_done), 64'd0);
    chk({tag, "_err"}, 64'(rec_err), 64'd0);
    chk({tag, "_byte_num"}, 64'(rec_byte_num), 64'd0);
    chk({tag, "_src_ip"}, 64'(src_ip), 64'd0);
    chk({tag, "_src_port"}, 64'(src_port), 64'd0);
    chk({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    int kind, keep;
    rst = 1'b1; dv = 1'b0; rxd = 8'h00;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Nominal frame, 8-byte payload 01..08.
    set_seq(8); build(); model(-1); send(-1, 1); check("nominal");
    // 6-byte payload with 12 pad bytes plus FCS.
    set_seq(6); f_pad = 16; build(); model(-1); send(-1, 1); check("padded");
    // Filtered frames leave the held outputs alone; a good frame follows.
    set_good(5); f_dport = 16'd1235; build(); model(-1); send(-1, 1); check("bad_port");
    set_good(5); f_type = 16'h0806; build(); model(-1); send(-1, 1); check("arp");
    set_good(5); f_proto = 8'd6; build(); model(-1); send(-1, 1); check("tcp");
    set_good(7); build(); model(-1); send(-1, 1); check("after_reject");
    // Broadcast MAC, IP options, too-short IHL, empty payload.
    set_good(9); f_mac = 48'hFFFF_FFFF_FFFF; build(); model(-1); send(-1, 1); check("bcast");
    set_seq(8); f_ihl = 4'd6; build(); model(-1); send(-1, 1); check("ihl6");
    set_good(8); f_ihl = 4'd4; build(); model(-1); send(-1, 1); check("ihl4");
    set_good(0); build(); model(-1); send(-1, 1); check("empty");
    // dv dropped after 5 of 8 payload bytes, then a normal frame.
    set_seq(8); build(); model(5); send(5, 2); check("trunc");
    set_good(8); build(); model(-1); send(-1, 1); check("after_trunc");
    // Reset during the IP header.
    set_good(8); build();
    for (int i = 0; i < 28; i++) begin
      @(negedge clk); dv = 1'b1; rxd = frm[i];
    end
    @(negedge clk); rst = 1'b1; dv = 1'b0;
    @(negedge clk); chk_zero("mid_rst");
    rst = 1'b0;
    m_src_ip = '0; m_src_port = '0; m_byte_num = '0;
    check("mid_rst");
    // Back-to-back frames separated by one idle cycle.
    set_good(6); build(); model(-1); send(-1, 1);
    set_good(11); build(); model(-1); send(-1, 1); check("b2b");

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 9);
      set_good($urandom_range(0, 20));
      f_ihl = 4'($urandom_range(5, 7));
      f_pad = $urandom_range(4, 12);
      case (kind)
        5: f_mac = 48'hFFFF_FFFF_FFFF;
        6: f_dport = PORT + 16'd1;
        7: f_type = 16'h86DD;
        8: f_proto = 8'd6;
        9: f_mac = {8'h02, 40'($urandom)};
        default: ;
      endcase
      build();
      if (kind == 4 && pay.size() > 0) begin
        keep = $urandom_range(0, pay.size() - 1);
        model(keep); send(keep, 2);
      end else begin
        model(-1); send(-1, $urandom_range(1, 3));
      end
      check("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
